// File: rtl/mod_segment_sequencer_pkg.sv
// Shared modulation settings package.
// Holds the settings struct produced by the settings controller, the
// transition-mode codes, the infinite-repetition marker, the sequencer state
// enum and a helper that tells whether a transition mode code is known.
package mod_segment_sequencer_pkg;

  localparam int MOD_IDX_W = 15;

  localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
  localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

  localparam logic [15:0] REP_INFINITE = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    STOPPED = 2'd2
  } seq_state_t;

  // Per-segment fields are indexed by segment number ([0] / [1]).
  typedef struct packed {
    logic                       UPDATE;
    logic                       REQ_RD_SEGMENT;
    logic [7:0]                 TRANSITION_MODE;
    logic [63:0]                TRANSITION_VALUE;
    logic [1:0][MOD_IDX_W-1:0]  CYCLE;
    logic [1:0][15:0]           FREQ_DIV;
    logic [1:0][15:0]           REP;
  } mod_settings_t;

  function automatic logic mode_is_valid(input logic [7:0] mode);
    return (mode == TRANSITION_MODE_SYNC_IDX) ||
           (mode == TRANSITION_MODE_SYS_TIME) ||
           (mode == TRANSITION_MODE_GPIO)     ||
           (mode == TRANSITION_MODE_IMMEDIATE);
  endfunction

endpackage

// File: rtl/mod_segment_sequencer_transition_trigger.sv
// transition_trigger: decides when a latched segment-transition request fires.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   armed        a request is latched and waiting
//   mode, value  latched transition mode and its parameter
//   sys_time     synchronised system time
//   gpio_in      asynchronous trigger pins (2-FF synchronised here)
//   wrap_now     the active segment wraps to index 0 at the next edge
//   stopped      the active segment has finished its repetitions
//   fire         combinational; the owner applies the switch at the next edge
module transition_trigger
  import mod_segment_sequencer_pkg::*;
#(
  parameter int GPIO_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              armed,
  input  logic [7:0]        mode,
  input  logic [63:0]       value,
  input  logic [63:0]       sys_time,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              wrap_now,
  input  logic              stopped,
  output logic              fire
);

  logic [GPIO_W-1:0] sync1, sync2, sync_prev;
  logic [GPIO_W-1:0] rise;
  logic              cond;

  // Two synchroniser flops, then a third flop holding the previous
  // synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= gpio_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

  always_comb begin
    cond = 1'b0;
    case (mode)
      TRANSITION_MODE_SYNC_IDX:  cond = wrap_now || stopped;
      TRANSITION_MODE_SYS_TIME:  cond = (sys_time >= value);
      TRANSITION_MODE_GPIO:      cond = rise[value[1:0]];
      TRANSITION_MODE_IMMEDIATE: cond = 1'b1;
      default:                   cond = 1'b0;
    endcase
    fire = armed && cond;
  end

endmodule

// File: rtl/mod_segment_sequencer.sv
// mod_segment_sequencer: turns the modulation settings into a running
// read index and active-segment select for the modulation BRAM, and owns the
// two-segment swap protocol (play one segment while the host fills the other).
// SETTINGS.UPDATE is a one-cycle valid strobe with no back-pressure: every
// strobe carrying a known transition mode is accepted on the edge it is seen;
// a strobe with an unknown mode is dropped entirely.
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset
//   SETTINGS      settings struct, sampled only when SETTINGS.UPDATE=1
//   SYS_TIME      synchronised system time
//   GPIO_IN       asynchronous trigger pins
//   SEGMENT       active segment
//   IDX           current sample index in SEGMENT
//   IDX_STB       one-cycle pulse on every IDX step or segment switch
//   STOP          active segment finished its repetitions, IDX held
//   PENDING       a non-immediate transition request is waiting
//   dbg_state     sequencer state (RUN / WAIT / STOPPED)
module mod_segment_sequencer
  import mod_segment_sequencer_pkg::*;
#(
  parameter int IDX_W  = MOD_IDX_W,
  parameter int GPIO_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  mod_settings_t     SETTINGS,
  input  logic [63:0]       SYS_TIME,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic              SEGMENT,
  output logic [IDX_W-1:0]  IDX,
  output logic              IDX_STB,
  output logic              STOP,
  output logic              PENDING,
  output seq_state_t        dbg_state
);

  seq_state_t       state;
  logic [IDX_W-1:0] cycle_cfg [2];
  logic [15:0]      div_cfg   [2];
  logic [15:0]      rep_cfg   [2];
  logic             req_seg;
  logic [7:0]       tr_mode;
  logic [63:0]      tr_value;
  logic             armed;
  logic [15:0]      presc;
  logic [15:0]      rep_cnt;

  logic             running, presc_tc, at_last, rep_done, wrap_now;
  logic             fire, stop_next, upd_valid, armed_next, pending_next;
  logic [7:0]       mode_next;

  assign running  = (state != STOPPED);
  // Comparisons use >= so a config rewritten mid-play can never strand the
  // counters past their terminal values.
  assign presc_tc = (presc >= div_cfg[SEGMENT] - 16'd1);
  assign at_last  = (IDX >= cycle_cfg[SEGMENT]);
  // rep_cnt holds completed cycles; the wrap in progress would complete cycle
  // rep_cnt+1, which is the last allowed one when rep_cnt reaches REP.
  assign rep_done = (rep_cfg[SEGMENT] != REP_INFINITE) && (rep_cnt >= rep_cfg[SEGMENT]);
  assign wrap_now = running && presc_tc && at_last;

  // A fire in the same cycle as a rep-limit stop wins.
  assign stop_next    = !fire && (!running || (wrap_now && rep_done));
  assign upd_valid    = SETTINGS.UPDATE && mode_is_valid(SETTINGS.TRANSITION_MODE);
  // An update coinciding with a fire: the fire uses the old request, the new
  // one is armed for evaluation from the next cycle.
  assign armed_next   = upd_valid ? 1'b1 : (fire ? 1'b0 : armed);
  assign mode_next    = upd_valid ? SETTINGS.TRANSITION_MODE : tr_mode;
  assign pending_next = armed_next && (mode_next != TRANSITION_MODE_IMMEDIATE);

  assign dbg_state = state;

  transition_trigger #(.GPIO_W(GPIO_W)) u_trigger (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .armed    (armed),
    .mode     (tr_mode),
    .value    (tr_value),
    .sys_time (SYS_TIME),
    .gpio_in  (GPIO_IN),
    .wrap_now (wrap_now),
    .stopped  (!running),
    .fire     (fire)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= RUN;
      SEGMENT  <= 1'b0;
      IDX      <= '0;
      IDX_STB  <= 1'b0;
      STOP     <= 1'b0;
      PENDING  <= 1'b0;
      presc    <= '0;
      rep_cnt  <= '0;
      req_seg  <= 1'b0;
      tr_mode  <= TRANSITION_MODE_SYNC_IDX;
      tr_value <= '0;
      armed    <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        cycle_cfg[s] <= '0;
        div_cfg[s]   <= 16'd1;
        rep_cfg[s]   <= REP_INFINITE;
      end
    end else begin
      IDX_STB <= 1'b0;
      if (fire) begin
        SEGMENT <= req_seg;
        IDX     <= '0;
        presc   <= '0;
        rep_cnt <= '0;
        IDX_STB <= 1'b1;
      end else if (running) begin
        if (presc_tc) begin
          presc <= '0;
          if (!at_last) begin
            IDX     <= IDX + IDX_W'(1);
            IDX_STB <= 1'b1;
          end else if (!rep_done) begin
            IDX     <= '0;
            rep_cnt <= rep_cnt + 16'd1;
            IDX_STB <= 1'b1;
          end
          // else: final wrap suppressed, IDX holds at CYCLE
        end else begin
          presc <= presc + 16'd1;
        end
      end

      STOP    <= stop_next;
      PENDING <= pending_next;
      armed   <= armed_next;
      if (stop_next)         state <= STOPPED;
      else if (pending_next) state <= WAIT;
      else                   state <= RUN;

      if (upd_valid) begin
        req_seg  <= SETTINGS.REQ_RD_SEGMENT;
        tr_mode  <= SETTINGS.TRANSITION_MODE;
        tr_value <= SETTINGS.TRANSITION_VALUE;
        for (int s = 0; s < 2; s++) begin
          cycle_cfg[s] <= SETTINGS.CYCLE[s];
          div_cfg[s]   <= (SETTINGS.FREQ_DIV[s] == 16'd0) ? 16'd1 : SETTINGS.FREQ_DIV[s];
          rep_cfg[s]   <= SETTINGS.REP[s];
        end
      end
    end
  end

endmodule

// File: doc/mod_segment_sequencer.md
Name: mod_segment_sequencer

Overview:
- Consumer of mod_settings_t. It turns the register-level request (UPDATE, REQ_RD_SEGMENT, TRANSITION_MODE/VALUE, CYCLE, FREQ_DIV, REP) into a running modulation read address and active-segment select for the modulation BRAM read side.
- It owns the two-segment swap protocol: one segment plays while the host fills the other; the swap happens at the requested transition condition; repetitions are counted and playback stops when they are exhausted.
- It sits between the settings controller and the modulation memory/multiplier pipeline.

Parameters:
- IDX_W, 15, width of the modulation sample index (32768-entry segments).
- GPIO_W, 4, number of GPIO inputs usable as a transition trigger.

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  reset; asynchronous assert, active-low.
- SETTINGS  input  mod_settings_t  settings struct; sampled only when SETTINGS.UPDATE=1.
- SYS_TIME  input  64  free-running synchronised system time.
- GPIO_IN  input  GPIO_W  asynchronous external trigger pins.
- SEGMENT  output  1  active segment.
- IDX  output  IDX_W  current sample index in SEGMENT.
- IDX_STB  output  1  one-cycle pulse on every IDX change or segment switch.
- STOP  output  1  active segment has finished its repetitions; IDX held.
- PENDING  output  1  a latched transition request is waiting for its condition.

Behaviour:
- Reset values:
  - SEGMENT=0, IDX=0, IDX_STB=0, STOP=0, PENDING=0.
  - State=RUN; prescaler=0; rep counter=0.
  - Latched config for segment 0: CYCLE=0, FREQ_DIV=1, REP=0xFFFF.
- Config latch:
  - On UPDATE=1, latch CYCLE/FREQ_DIV/REP for both segments plus REQ_RD_SEGMENT, TRANSITION_MODE and TRANSITION_VALUE.
  - FREQ_DIV=0 is stored as 1.
- Index generation in RUN/WAIT:
  - The prescaler counts 0..FREQ_DIV[SEGMENT]-1.
  - At the terminal count, IDX increments and IDX_STB pulses.
  - IDX wraps from CYCLE[SEGMENT] (last index, i.e. length-1) to 0; each wrap increments the rep counter.
- Repetition:
  - If REP[SEGMENT]!=0xFFFF and a wrap would complete cycle number REP+1, the block enters STOPPED instead of wrapping.
  - In STOPPED: IDX holds at CYCLE, STOP=1, no further IDX_STB.
  - REP=0xFFFF means infinite repetition.
- Transition modes (TRANSITION_MODE):
  - 0x00 SYNC_IDX: fire on the cycle the wrap to IDX=0 would occur; in STOPPED, fire on the next cycle.
  - 0x01 SYS_TIME: fire when SYS_TIME >= TRANSITION_VALUE; a time already in the past fires on the next cycle.
  - 0x02 GPIO: fire on a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]], after an internal 2-FF synchroniser plus edge register.
  - 0xFF IMMEDIATE: fire on the cycle after UPDATE, without entering WAIT.
  - Any other code: request discarded; state and outputs unchanged.
- State machine RUN / WAIT / STOPPED:
  - UPDATE with a non-immediate valid mode: → WAIT, PENDING=1.
  - WAIT while the old segment keeps playing (index generation and rep counting continue): on fire → RUN.
  - WAIT while the old segment reaches its rep limit: → STOPPED with PENDING still 1; the condition is still evaluated.
- Firing (registered one cycle after the condition is true):
  - SEGMENT<=REQ_RD_SEGMENT, IDX<=0, prescaler<=0, rep counter<=0.
  - STOP<=0, PENDING<=0, IDX_STB=1.
  - Requesting the already-active segment is legal and restarts it from IDX 0.
- Simultaneous events:
  - UPDATE during WAIT replaces the pending request (latest wins) and restarts condition evaluation with the new mode.
  - UPDATE in the same cycle as a fire: the fire completes, and the new request is latched and evaluated from the next cycle.
  - Rep-limit stop and fire in the same cycle: the fire wins.
- Latency:
  - IMMEDIATE: UPDATE sampled at edge k; SEGMENT/IDX updated at edge k+1.
  - GPIO: pin edge to SEGMENT switch is ≤4 cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending request is lost.

Decomposition:
- Shared settings package gains:
  - TRANSITION_MODE_SYNC_IDX=8'h00, _SYS_TIME=8'h01, _GPIO=8'h02, _IMMEDIATE=8'hFF.
  - REP_INFINITE=16'hFFFF.
  - A seq_state_t enum {RUN, WAIT, STOPPED}.
- One sub-module: transition_trigger.
  - Combinational mode decode plus the registered GPIO synchroniser/edge detect.
  - Outputs a single-cycle fire pulse.
  - It is reused by the STM sequencer.

Test Plan:
- Basic playback: reset; UPDATE IMMEDIATE seg0, CYCLE=3, FREQ_DIV=2, REP=0xFFFF → IDX 0,0,1,1,2,2,3,3,0…, IDX_STB every 2 cycles, SEGMENT=0, STOP never set.
- Repetition stop: seg0 CYCLE=1, FREQ_DIV=1, REP=1 → IDX 0,1,0,1 then held at 1; STOP=1 after the 4th sample; no further IDX_STB.
- SYNC_IDX swap: seg0 running CYCLE=9; at IDX=4, UPDATE SYNC_IDX seg1 CYCLE=2 → PENDING=1 through IDX 9; next sample is seg1 IDX 0; PENDING=0.
- SYS_TIME swap: UPDATE mode 0x01, VALUE=1000, SYS_TIME at 900 → switch registered exactly one cycle after SYS_TIME=1000; a second request with VALUE=500 fires on the next cycle.
- GPIO swap and override: UPDATE GPIO pin 2, then before the edge UPDATE IMMEDIATE seg0 → immediate swap, PENDING=0, and a later GPIO_IN[2] edge does nothing; an unknown mode 0x55 leaves outputs unchanged.
- Reset mid-WAIT: assert RESET_N=0 while PENDING=1 with mode 0x01 → all outputs 0 asynchronously; after release, SEGMENT=0 and no swap occurs when SYS_TIME passes the old value.
